// File: rtl/fetch_queue_if.sv
// Signal bundle between the prefetch queue, the instruction memory port,
// the EX-stage redirect source and the decode stage.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc, pc_plus_4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus_4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction prefetcher: credit-limited memory requests, in-order
// {pc, instr} queue toward decode, wrong-path responses dropped after redirect.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] count_r;
  logic [OW-1:0] outst_r;
  logic [OW-1:0] discard_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [PW-1:0] pend_wr_r;
  logic [PW-1:0] pend_rd_r;
  logic [31:0]   q_pc_r    [DEPTH];
  logic [31:0]   q_instr_r [DEPTH];
  logic [31:0]   pend_pc_r [MAX_OUTST];

  logic rsp_s;
  logic req_s;
  logic accept_s;
  logic push_s;
  logic pop_s;

  // The pending-PC ring need not be a power of two deep.
  function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
    if (32'(p) == 32'(MAX_OUTST - 1)) begin
      pend_inc = {PW{1'b0}};
    end else begin
      pend_inc = p + PW'(1'b1);
    end
  endfunction

  // Credit check and handshake qualifiers; a redirect cycle neither pushes nor pops.
  always_comb begin
    rsp_s    = bus.imem_rvalid && (outst_r != {OW{1'b0}});
    req_s    = rst && !bus.redirect &&
               (32'(outst_r) < 32'(MAX_OUTST)) &&
               ((32'(count_r) + 32'(outst_r)) < 32'(DEPTH));
    accept_s = req_s && bus.imem_gnt;
    push_s   = !bus.redirect && rsp_s && (discard_r == {OW{1'b0}});
    pop_s    = !bus.redirect && (count_r != {CW{1'b0}}) && bus.instr_ready;
  end

  // Memory request and decode-facing head of queue.
  always_comb begin
    bus.imem_req  = req_s;
    bus.imem_addr = fetch_pc_r;
    if (count_r != {CW{1'b0}}) begin
      bus.instr_valid = 1'b1;
      bus.instr       = q_instr_r[head_r];
      bus.pc          = q_pc_r[head_r];
      bus.pc_plus_4   = q_pc_r[head_r] + 32'd4;
    end else begin
      bus.instr_valid = 1'b0;
      bus.instr       = 32'h0;
      bus.pc          = 32'h0;
      bus.pc_plus_4   = 32'h0;
    end
  end

  // Fetch PC, queue occupancy and in-flight / discard accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
      count_r    <= {CW{1'b0}};
      outst_r    <= {OW{1'b0}};
      discard_r  <= {OW{1'b0}};
      head_r     <= {AW{1'b0}};
      tail_r     <= {AW{1'b0}};
      pend_wr_r  <= {PW{1'b0}};
      pend_rd_r  <= {PW{1'b0}};
    end else begin
      if (bus.redirect) begin
        fetch_pc_r <= {bus.redirect_pc[31:2], 2'b00};
        count_r    <= {CW{1'b0}};
        head_r     <= tail_r;
        discard_r  <= outst_r - OW'(rsp_s);
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (push_s) begin
          tail_r <= tail_r + AW'(1'b1);
        end
        if (pop_s) begin
          head_r <= head_r + AW'(1'b1);
        end
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
        if (rsp_s && (discard_r != {OW{1'b0}})) begin
          discard_r <= discard_r - OW'(1'b1);
        end
      end
      // Discarded responses still retire their pending PC.
      outst_r <= outst_r + OW'(accept_s) - OW'(rsp_s);
      if (accept_s) begin
        pend_wr_r <= pend_inc(pend_wr_r);
      end
      if (rsp_s) begin
        pend_rd_r <= pend_inc(pend_rd_r);
      end
    end
  end

  // Queue and pending-PC storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_pc_r[tail_r]    <= pend_pc_r[pend_rd_r];
      q_instr_r[tail_r] <= bus.imem_rdata;
    end
    if (accept_s) begin
      pend_pc_r[pend_wr_r] <= fetch_pc_r;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory with variable latency
// plus a queue-level reference model, checked on every negative clock edge.
module tb_fetch_queue;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int seq = 0;
  int last_due = 0;
  int gnt_pct, ready_pct, redir_pct, lat_min, lat_max;
  int first_valid, rel_cyc;
  bit rst_drive, redir_once, stale_once;
  logic [31:0] redir_target;

  // reference model: fetch pointer, PCs in flight, visible queue, responses to drop
  logic [31:0] m_fpc;
  logic [31:0] m_pend[$];
  logic [63:0] m_q[$];
  int          m_disc;
  rsp_t        mem_q[$];

  logic [31:0] obs_pc[$];
  logic [31:0] obs_p4[$];
  logic [31:0] acc_addr[$];
  logic        s_req, s_valid;
  logic [31:0] s_addr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, need 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic exp_req();
    return rst && !bus.redirect && (m_pend.size() < MAX_OUTST) &&
           ((m_q.size() + m_pend.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_fpc = 32'h0;
    m_pend.delete();
    m_q.delete();
    m_disc = 0;
    mem_q.delete();
    last_due = cyc;
  endtask

  task automatic model_step();
    logic        acc, rv;
    logic [31:0] rpc;
    rsp_t        r;
    int          lat;
    acc = exp_req() && bus.imem_gnt;
    rv  = bus.imem_rvalid && (m_pend.size() > 0);
    rpc = 32'h0;
    if (rv) rpc = m_pend.pop_front();
    if (bus.redirect) begin
      m_disc = m_pend.size();
      m_q.delete();
      m_fpc = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (m_q.size() > 0 && bus.instr_ready) void'(m_q.pop_front());
      if (rv) begin
        if (m_disc > 0) m_disc--;
        else m_q.push_back({rpc, bus.imem_rdata});
      end
      if (acc) begin
        m_pend.push_back(m_fpc);
        lat    = $urandom_range(lat_max, lat_min);
        r.data = m_fpc ^ {seq[15:0], 16'hA5C3};
        r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = r.due;
        seq++;
        mem_q.push_back(r);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic drive();
    rsp_t r;
    if (rst_drive) begin
      rst = 1'b1;
    end else begin
      rst = 1'b0;
      model_reset();
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (stale_once) begin
      bus.imem_rvalid = 1'b1;
      stale_once = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = r.data;
    end
    bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
    bus.instr_ready = ($urandom_range(99) < ready_pct);
    if (redir_once) begin
      bus.redirect    = 1'b1;
      bus.redirect_pc = redir_target;
      redir_once = 1'b0;
    end else begin
      bus.redirect    = ($urandom_range(99) < redir_pct);
      bus.redirect_pc = $urandom;
    end
  endtask

  task automatic check();
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_p4;
    e_valid = (m_q.size() > 0);
    e_pc = 32'h0; e_instr = 32'h0; e_p4 = 32'h0;
    if (e_valid) begin
      e_pc    = m_q[0][63:32];
      e_instr = m_q[0][31:0];
      e_p4    = e_pc + 32'd4;
    end
    cmp("imem_req", 32'(bus.imem_req), 32'(exp_req()));
    cmp("imem_addr", bus.imem_addr, m_fpc);
    cmp("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
    cmp("instr", bus.instr, e_instr);
    cmp("pc", bus.pc, e_pc);
    cmp("pc_plus_4", bus.pc_plus_4, e_p4);
    s_req = bus.imem_req; s_valid = bus.instr_valid; s_addr = bus.imem_addr;
    if (bus.instr_valid && first_valid < 0) first_valid = cyc;
    if (bus.instr_valid && bus.instr_ready) begin
      obs_pc.push_back(bus.pc);
      obs_p4.push_back(bus.pc_plus_4);
    end
    if (bus.imem_req && bus.imem_gnt) acc_addr.push_back(bus.imem_addr);
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check();
    @(posedge clk);
    if (rst) model_step();
    cyc++;
  endtask

  task automatic clear_obs();
    obs_pc.delete(); obs_p4.delete(); acc_addr.delete();
  endtask

  task automatic hold_reset(input int n);
    rst_drive = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic release_rst();
    rst_drive   = 1'b1;
    rel_cyc     = cyc;
    first_valid = -1;
    clear_obs();
  endtask

  task automatic knobs(input int g, input int rdy, input int rd, input int lmin, input int lmax);
    gnt_pct = g; ready_pct = rdy; redir_pct = rd; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
    rst_drive = 1'b0; redir_once = 1'b0; stale_once = 1'b0; redir_target = 32'h0;
    first_valid = -1; rel_cyc = 0;
    model_reset();

    // T1: always granted, 1-cycle latency; first valid in the third cycle counting release
    knobs(100, 100, 0, 1, 1);
    hold_reset(3);
    release_rst();
    repeat (8) cycle();
    cmp("t1_first_valid_delay", 32'(first_valid - rel_cyc), 32'd2);
    for (int i = 0; i < 4; i++) cmp("t1_pc_seq", qget(obs_pc, i), 32'(4 * i));

    // T2: decode stalled until the queue fills, then drains in order
    knobs(100, 0, 0, 1, 1);
    hold_reset(2);
    release_rst();
    repeat (8) cycle();
    cmp("t2_req_low_when_full", 32'(s_req), 32'd0);
    cmp("t2_head_valid_when_full", 32'(s_valid), 32'd1);
    clear_obs();
    ready_pct = 100;
    repeat (8) cycle();
    for (int i = 0; i < 4; i++) cmp("t2_drain_pc", qget(obs_pc, i), 32'(4 * i));
    cmp("t2_resume_addr", qget(acc_addr, 0), 32'h10);

    // T3: two requests in flight at latency 3, redirect to an unaligned target
    knobs(100, 100, 0, 3, 3);
    hold_reset(2);
    release_rst();
    repeat (2) cycle();
    redir_once = 1'b1; redir_target = 32'h103;
    cycle();
    clear_obs();
    repeat (12) cycle();
    cmp("t3_first_pc", qget(obs_pc, 0), 32'h100);
    cmp("t3_first_pc_plus_4", qget(obs_p4, 0), 32'h104);

    // T4: redirect, response and pop land in the same cycle with two queued
    knobs(100, 0, 0, 1, 1);
    hold_reset(2);
    release_rst();
    repeat (3) cycle();
    ready_pct = 100; redir_once = 1'b1; redir_target = 32'h200;
    cycle();
    clear_obs();
    cycle();
    cmp("t4_empty_after_redirect", 32'(s_valid), 32'd0);
    repeat (6) cycle();
    cmp("t4_first_pc", qget(obs_pc, 0), 32'h200);

    // T5: grant withheld for three cycles, then a single grant
    knobs(0, 100, 0, 1, 1);
    hold_reset(2);
    release_rst();
    repeat (3) begin
      cycle();
      cmp("t5_req_held", 32'(s_req), 32'd1);
      cmp("t5_addr_stable", s_addr, 32'h0);
    end
    gnt_pct = 100;
    cycle();
    gnt_pct = 0;
    cycle();
    cmp("t5_addr_step", s_addr, 32'h4);

    // T6: asynchronous reset with two requests outstanding and a valid head
    knobs(100, 0, 0, 2, 2);
    hold_reset(2);
    release_rst();
    repeat (5) cycle();
    cmp("t6_valid_before_reset", 32'(s_valid), 32'd1);
    #2;
    rst = 1'b0;
    rst_drive = 1'b0;
    #1;
    cmp("t6_async_req", 32'(bus.imem_req), 32'd0);
    cmp("t6_async_valid", 32'(bus.instr_valid), 32'd0);
    cmp("t6_async_instr", bus.instr, 32'h0);
    cmp("t6_async_pc", bus.pc, 32'h0);
    cmp("t6_async_pc_plus_4", bus.pc_plus_4, 32'h0);
    model_reset();
    knobs(100, 100, 0, 1, 1);
    hold_reset(2);
    stale_once = 1'b1;
    release_rst();
    repeat (6) cycle();
    cmp("t6_first_fetch", qget(acc_addr, 0), 32'h0);
    cmp("t6_first_pc", qget(obs_pc, 0), 32'h0);

    // Random segments, including a redirect near the top of the address space
    for (int s = 0; s < 8; s++) begin
      knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(8, 0),
            1, $urandom_range(5, 1));
      if (s == 4) begin
        redir_once = 1'b1;
        redir_target = 32'hFFFF_FFF9;
      end
      repeat (300) cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
